alu_issue_wb: RTL and testbench

//  Upstream/downstream wrapper for the combinational 8-bit ALU: accepts 16-bit instructions (valid/ready),

---
 rtl/mips_lite_pkg.sv | 44 ++++
 rtl/alu_issue_wb_if.sv | 45 ++++
 rtl/alu_issue_wb_reg_file.sv | 50 +++++
 rtl/alu_issue_wb.sv | 134 +++++++++++++
 tb/tb_alu_issue_wb.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_lite_pkg                                                |
// | Description : Shared constants for the ALU issue/writeback wrapper:        |
// |               opcodes, instruction field positions and default widths.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_lite_pkg;

  localparam int c_DATA_W  = 8;
  localparam int c_ADDR_W  = 3;
  localparam int c_INSTR_W = 16;

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_MUL  = 3'b010;
  localparam logic [2:0] c_OP_DIV  = 3'b011;
  localparam logic [2:0] c_OP_AND  = 3'b100;
  localparam logic [2:0] c_OP_OR   = 3'b101;
  localparam logic [2:0] c_OP_XOR  = 3'b110;
  localparam logic [2:0] c_OP_ZERO = 3'b111;

  localparam int c_OP_MSB = 15;
  localparam int c_OP_LSB = 13;
  localparam int c_RD_MSB = 12;
  localparam int c_RD_LSB = 10;
  localparam int c_RS_MSB = 9;
  localparam int c_RS_LSB = 7;
  localparam int c_RT_MSB = 6;
  localparam int c_RT_LSB = 4;

  // Packs an instruction word; the low nibble carries no meaning.
  function automatic logic [c_INSTR_W-1:0] make_instr(
    input logic [2:0]          op,
    input logic [c_ADDR_W-1:0] rd,
    input logic [c_ADDR_W-1:0] rs,
    input logic [c_ADDR_W-1:0] rt,
    input logic [3:0]          pad
  );
    return {op, rd, rs, rt, pad};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_wb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_wb_if                                              |
// | Description : Instruction, ALU, external-load and writeback signals of     |
// |               the issue/writeback wrapper; slave is the wrapper's view.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_issue_wb_if
  import mips_lite_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W,
  parameter int CNT_W  = 16
);

  logic                 instr_valid;
  logic                 instr_ready;
  logic [c_INSTR_W-1:0] instr;

  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [2:0]           alu_op;
  logic [DATA_W-1:0]    alu_result;

  logic                 ext_we;
  logic [ADDR_W-1:0]    ext_waddr;
  logic [DATA_W-1:0]    ext_wdata;

  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_rd;
  logic [DATA_W-1:0]    wb_data;
  logic [CNT_W-1:0]     retired_count;

  modport master (
    output instr_valid, instr, alu_result, ext_we, ext_waddr, ext_wdata,
    input  instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, retired_count
  );

  modport slave (
    input  instr_valid, instr, alu_result, ext_we, ext_waddr, ext_wdata,
    output instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, retired_count
  );

endinterface
`default_nettype wire

// File: rtl/alu_issue_wb_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file                                                     |
// | Description : NUM_REGS x DATA_W registers, two async reads, writeback and  |
// |               external write ports (writeback wins), R0 reads as zero.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_file #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] rd_addr_a,
  output logic      [DATA_W-1:0] rd_data_a,
  input  wire logic [ADDR_W-1:0] rd_addr_b,
  output logic      [DATA_W-1:0] rd_data_b,
  input  wire logic              wb_we,
  input  wire logic [ADDR_W-1:0] wb_addr,
  input  wire logic [DATA_W-1:0] wb_data,
  input  wire logic              ext_we,
  input  wire logic [ADDR_W-1:0] ext_addr,
  input  wire logic [DATA_W-1:0] ext_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // The writeback assignment comes last so it overrides an external write
  // to the same register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (ext_we && (ext_addr != '0)) begin
        r_mem[ext_addr] <= ext_data;
      end
      if (wb_we && (wb_addr != '0)) begin
        r_mem[wb_addr] <= wb_data;
      end
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : r_mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : r_mem[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/alu_issue_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_wb                                                 |
// | Description : Two-stage issue -> execute/writeback wrapper around an       |
// |               external combinational 8-bit ALU. Define ALU_FORWARD_EN to   |
// |               forward the in-flight result instead of stalling on RAW.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_wb
  import mips_lite_pkg::*;
#(
  parameter  int DATA_W   = c_DATA_W,
  parameter  int NUM_REGS = 8,
  parameter  int CNT_W    = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input wire logic      clk,
  input wire logic      rst,
  alu_issue_wb_if.slave bus
);

  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic              w_unused_pad;

  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;
  logic              w_haz_a;
  logic              w_haz_b;
  logic              w_stall;
  logic              w_issue;

  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_alu_op;
  logic              r_ex_valid;
  logic [ADDR_W-1:0] r_ex_rd;

  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [CNT_W-1:0]  r_retired;

  assign w_op         = bus.instr[c_OP_MSB:c_OP_LSB];
  assign w_rd         = bus.instr[c_RD_MSB:c_RD_LSB];
  assign w_rs         = bus.instr[c_RS_MSB:c_RS_LSB];
  assign w_rt         = bus.instr[c_RT_MSB:c_RT_LSB];
  assign w_unused_pad = ^bus.instr[3:0];

  reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (w_rs),
    .rd_data_a (w_rf_a),
    .rd_addr_b (w_rt),
    .rd_data_b (w_rf_b),
    .wb_we     (r_ex_valid),
    .wb_addr   (r_ex_rd),
    .wb_data   (bus.alu_result),
    .ext_we    (bus.ext_we),
    .ext_addr  (bus.ext_waddr),
    .ext_data  (bus.ext_wdata)
  );

  // Only the instruction in execute can be missing from the register file;
  // anything older has already been written back.
  assign w_haz_a = r_ex_valid && (r_ex_rd != '0) && (r_ex_rd == w_rs);
  assign w_haz_b = r_ex_valid && (r_ex_rd != '0) && (r_ex_rd == w_rt);

`ifdef ALU_FORWARD_EN
  assign w_opnd_a = w_haz_a ? bus.alu_result : w_rf_a;
  assign w_opnd_b = w_haz_b ? bus.alu_result : w_rf_b;
  assign w_stall  = 1'b0;
`else
  assign w_opnd_a = w_rf_a;
  assign w_opnd_b = w_rf_b;
  assign w_stall  = w_haz_a || w_haz_b;
`endif

  assign bus.instr_ready = !bus.ext_we && !w_stall;
  assign w_issue         = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_ex_valid <= 1'b0;
      r_ex_rd    <= '0;
    end else begin
      r_ex_valid <= w_issue;
      if (w_issue) begin
        r_alu_a  <= w_opnd_a;
        r_alu_b  <= w_opnd_b;
        r_alu_op <= w_op;
        r_ex_rd  <= w_rd;
      end
    end
  end

  // The result is reported even when rd is R0; only the register write drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_retired  <= '0;
    end else begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= bus.alu_result;
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign bus.alu_a         = r_alu_a;
  assign bus.alu_b         = r_alu_b;
  assign bus.alu_op        = r_alu_op;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_rd         = r_wb_rd;
  assign bus.wb_data       = r_wb_data;
  assign bus.retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_wb                                              |
// | Description : Directed and random bench for alu_issue_wb with an          |
// |               architectural in-order register model.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_wb;
  import mips_lite_pkg::*;

`ifdef ALU_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_wb_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) bus ();

  alu_issue_wb #(.DATA_W(8), .NUM_REGS(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      c_OP_ADD: return a + b;
      c_OP_SUB: return a - b;
      c_OP_MUL: return 8'((16'(a) * 16'(b)));
      c_OP_DIV: return (b == 8'd0) ? 8'hFF : a / b;
      c_OP_AND: return a & b;
      c_OP_OR:  return a | b;
      c_OP_XOR: return a ^ b;
      default:  return 8'h00;
    endcase
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural state plus what the outputs should show after each edge.
  logic [7:0]  m_regs [8];
  logic        m_ex_v;
  logic [2:0]  m_ex_rd;
  logic [7:0]  m_ex_data;
  logic        m_accept;
  logic        e_wb_v;
  logic [2:0]  e_wb_rd;
  logic [7:0]  e_wb_data;
  logic [7:0]  e_a, e_b;
  logic [2:0]  e_op;
  logic [15:0] e_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ex_v = 1'b0; m_ex_rd = '0; m_ex_data = '0; m_accept = 1'b0;
    e_wb_v = 1'b0; e_wb_rd = '0; e_wb_data = '0;
    e_a = '0; e_b = '0; e_op = '0; e_cnt = '0;
  endtask

  // One clock: check ready, advance the model across the edge, check outputs.
  task automatic step();
    logic [2:0] op, rd, rs, rt;
    logic [7:0] res;
    logic       hz, exp_ready;
    #1;
    op = bus.instr[15:13]; rd = bus.instr[12:10];
    rs = bus.instr[9:7];   rt = bus.instr[6:4];
    hz = m_ex_v && (m_ex_rd != 3'd0) && ((m_ex_rd == rs) || (m_ex_rd == rt));
    exp_ready = !bus.ext_we && !(!FWD && hz);
    check("instr_ready", bus.instr_ready, exp_ready);
    m_accept = bus.instr_valid && exp_ready && !rst;
    if (rst) begin
      reset_model();
    end else begin
      if (bus.ext_we && (bus.ext_waddr != 3'd0) && !(m_ex_v && (m_ex_rd == bus.ext_waddr)))
        m_regs[bus.ext_waddr] = bus.ext_wdata;
      e_wb_v = m_ex_v;
      if (m_ex_v) begin
        e_wb_rd   = m_ex_rd;
        e_wb_data = m_ex_data;
        e_cnt     = e_cnt + 16'd1;
      end
      if (m_accept) begin
        e_a  = m_regs[rs];
        e_b  = m_regs[rt];
        e_op = op;
        res  = alu_fn(op, m_regs[rs], m_regs[rt]);
        if (rd != 3'd0) m_regs[rd] = res;
        m_ex_rd   = rd;
        m_ex_data = res;
      end
      m_ex_v = m_accept;
    end
    @(posedge clk);
    #1;
    check("wb_valid", bus.wb_valid, e_wb_v);
    check("wb_rd", bus.wb_rd, e_wb_rd);
    check("wb_data", bus.wb_data, e_wb_data);
    check("alu_a", bus.alu_a, e_a);
    check("alu_b", bus.alu_b, e_b);
    check("alu_op", bus.alu_op, e_op);
    check("retired_count", bus.retired_count, e_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.instr_valid = 1'b0; bus.ext_we = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic ext_load(input logic [2:0] a, input logic [7:0] d);
    bus.ext_we = 1'b1; bus.ext_waddr = a; bus.ext_wdata = d;
    step();
    bus.ext_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, output int stalls);
    bus.instr = ins; bus.instr_valid = 1'b1; stalls = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (m_accept) break;
      stalls++;
    end
    check("issue_accepted", m_accept, 1'b1);
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic       pending;
    logic [2:0] last_rd, rs, rt;

    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0;
    bus.ext_we = 1'b0; bus.ext_waddr = '0; bus.ext_wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_model();
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_rd", bus.wb_rd, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_count", bus.retired_count, 0);
    rst = 1'b0;

    // Basic ADD with latency check.
    ext_load(3'd1, 8'd40); ext_load(3'd2, 8'd64);
    issue(make_instr(c_OP_ADD, 3'd3, 3'd1, 3'd2, 4'h5), s);
    check("t1_alu_a", bus.alu_a, 40);
    check("t1_alu_b", bus.alu_b, 64);
    check("t1_alu_op", bus.alu_op, c_OP_ADD);
    check("t1_wb_early", bus.wb_valid, 0);
    idle(1);
    check("t1_wb_valid", bus.wb_valid, 1);
    check("t1_wb_rd", bus.wb_rd, 3);
    check("t1_wb_data", bus.wb_data, 104);
    idle(1);
    check("t1_wb_pulse", bus.wb_valid, 0);

    // DIV then ZERO, counter.
    do_reset();
    ext_load(3'd1, 8'd20); ext_load(3'd2, 8'd8);
    issue(make_instr(c_OP_DIV, 3'd4, 3'd1, 3'd2, 4'h0), s);
    idle(1);
    check("t2_div", bus.wb_data, 2);
    issue(make_instr(c_OP_ZERO, 3'd5, 3'd1, 3'd2, 4'hF), s);
    idle(1);
    check("t2_zero", bus.wb_data, 0);
    check("t2_count", bus.retired_count, 2);
    issue(make_instr(c_OP_OR, 3'd6, 3'd5, 3'd5, 4'h0), s);
    idle(1);
    check("t2_r5", bus.wb_data, 0);

    // Back-to-back dependency.
    do_reset();
    ext_load(3'd1, 8'd40); ext_load(3'd2, 8'd64);
    issue(make_instr(c_OP_ADD, 3'd3, 3'd1, 3'd2, 4'h0), s);
    issue(make_instr(c_OP_SUB, 3'd4, 3'd3, 3'd1, 4'h0), s);
    check("t3_stalls", s, FWD ? 0 : 1);
    idle(1);
    check("t3_wb_rd", bus.wb_rd, 4);
    check("t3_wb_data", bus.wb_data, 64);

    // Write to R0, then R0 reads zero.
    ext_load(3'd1, 8'hD6); ext_load(3'd2, 8'h4A);
    issue(make_instr(c_OP_AND, 3'd0, 3'd1, 3'd2, 4'h0), s);
    idle(1);
    check("t4_wb_data", bus.wb_data, 8'h42);
    check("t4_wb_rd", bus.wb_rd, 0);
    issue(make_instr(c_OP_OR, 3'd6, 3'd0, 3'd1, 4'h0), s);
    idle(1);
    check("t4_r0_read", bus.wb_data, 8'hD6);

    // External write collides with writeback.
    ext_load(3'd1, 8'd40); ext_load(3'd2, 8'd64);
    issue(make_instr(c_OP_ADD, 3'd3, 3'd1, 3'd2, 4'h0), s);
    bus.ext_we = 1'b1; bus.ext_waddr = 3'd3; bus.ext_wdata = 8'd7;
    bus.instr_valid = 1'b1; bus.instr = make_instr(c_OP_OR, 3'd5, 3'd6, 3'd6, 4'h0);
    #1;
    check("t5_ready", bus.instr_ready, 0);
    step();
    bus.ext_we = 1'b0; bus.instr_valid = 1'b0;
    issue(make_instr(c_OP_OR, 3'd6, 3'd3, 3'd3, 4'h0), s);
    idle(1);
    check("t5_r3", bus.wb_data, 104);

    // Reset with an instruction in execute.
    for (int i = 1; i < 8; i++) ext_load(3'(i), 8'(i * 3 + 1));
    issue(make_instr(c_OP_ADD, 3'd3, 3'd1, 3'd2, 4'h0), s);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_wb_valid", bus.wb_valid, 0);
    check("t6_count", bus.retired_count, 0);
    check("t6_alu_a", bus.alu_a, 0);
    idle(1);
    check("t6_no_late_wb", bus.wb_valid, 0);
    for (int i = 1; i < 8; i++) begin
      issue(make_instr(c_OP_OR, 3'd0, 3'(i), 3'(i), 4'h0), s);
      idle(1);
      check("t6_reg_cleared", bus.wb_data, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    pending = 1'b0;
    last_rd = 3'd1;
    for (int c = 0; c < 1500; c++) begin
      if (!pending) begin
        bus.instr_valid = ($urandom_range(9) < 7);
        rs = ($urandom_range(9) < 3) ? last_rd : 3'($urandom_range(7));
        rt = ($urandom_range(9) < 3) ? last_rd : 3'($urandom_range(7));
        bus.instr = make_instr(3'($urandom_range(7)), 3'($urandom_range(7)), rs, rt,
                               4'($urandom_range(15)));
      end
      bus.ext_we    = ($urandom_range(7) == 0);
      bus.ext_waddr = 3'($urandom_range(7));
      bus.ext_wdata = 8'($urandom_range(255));
      rst           = ($urandom_range(199) == 0);
      step();
      if (m_accept) last_rd = bus.instr[12:10];
      pending = bus.instr_valid && !m_accept;
    end
    rst = 1'b0; bus.instr_valid = 1'b0; bus.ext_we = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
